// File: rtl/sdpram_rowop_seq.sv
// Row-operation sequencer: streams row pairs from the dual-port matrix RAM to an external
// row ALU over valid/ready and writes each result row back through RAM port A.
module sdpram_rowop_seq #(
    parameter int unsigned DATA_W = 256,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_a,
    input  logic [ADDR_W-1:0] src_b,
    input  logic [ADDR_W-1:0] dst,
    input  logic [4:0]        nrows,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] ram_addr_a,
    output logic              ram_wen_a,
    output logic [DATA_W-1:0] ram_d_a,
    input  logic [DATA_W-1:0] ram_q_a,
    output logic [ADDR_W-1:0] ram_addr_b,
    output logic              ram_wen_b,
    output logic [DATA_W-1:0] ram_d_b,
    input  logic [DATA_W-1:0] ram_q_b,
    output logic              op_valid,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              op_ready,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready
);

    typedef enum logic [2:0] {
        StIdle, StRead, StWait, StIssue, StResult, StWrite, StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] src_a_q, src_b_q, dst_q;
    logic [4:0]        nrows_q, idx_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, res_q;
    logic              err_q;
    logic [ADDR_W:0]   end_a, end_b, end_d;
    logic              legal, last_row, accept;

    // Last touched row computed one bit wider so an overrun cannot wrap back into range.
    assign end_a = (ADDR_W+1)'(src_a) + (ADDR_W+1)'(nrows) - (ADDR_W+1)'(1);
    assign end_b = (ADDR_W+1)'(src_b) + (ADDR_W+1)'(nrows) - (ADDR_W+1)'(1);
    assign end_d = (ADDR_W+1)'(dst) + (ADDR_W+1)'(nrows) - (ADDR_W+1)'(1);

    assign legal = (nrows != 5'd0) && (32'(nrows) <= DEPTH)
                   && (end_a <= (ADDR_W+1)'(DEPTH - 1))
                   && (end_b <= (ADDR_W+1)'(DEPTH - 1))
                   && (end_d <= (ADDR_W+1)'(DEPTH - 1));

    assign accept   = (state_q == StIdle) && start && legal;
    assign last_row = (idx_q == nrows_q - 5'd1);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (accept) state_d = StRead;
            StRead:   state_d = StWait;
            StWait:   state_d = StIssue;
            StIssue:  if (op_ready) state_d = StResult;
            StResult: if (res_valid) state_d = StWrite;
            StWrite:  state_d = last_row ? StDone : StRead;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            src_a_q <= '0;
            src_b_q <= '0;
            dst_q   <= '0;
            nrows_q <= '0;
            idx_q   <= '0;
            op_a_q  <= '0;
            op_b_q  <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == StIdle) && start && !legal;
            if (accept) begin
                src_a_q <= src_a;
                src_b_q <= src_b;
                dst_q   <= dst;
                nrows_q <= nrows;
                idx_q   <= '0;
            end
            if (state_q == StWait) begin
                op_a_q <= ram_q_a;
                op_b_q <= ram_q_b;
            end
            if (state_q == StResult && res_valid) res_q <= res_data;
            if (state_q == StWrite && !last_row) idx_q <= idx_q + 5'd1;
        end
    end

    always_comb begin
        busy       = (state_q != StIdle);
        done       = (state_q == StDone);
        err        = err_q;
        op_valid   = (state_q == StIssue);
        res_ready  = (state_q == StResult);
        ram_wen_a  = (state_q == StWrite);
        ram_d_a    = '0;
        ram_addr_a = '0;
        ram_addr_b = '0;
        ram_wen_b  = 1'b0;
        ram_d_b    = '0;
        op_a       = op_a_q;
        op_b       = op_b_q;
        if (state_q == StRead) begin
            ram_addr_a = src_a_q + ADDR_W'(idx_q);
            ram_addr_b = src_b_q + ADDR_W'(idx_q);
        end
        if (state_q == StWrite) begin
            ram_addr_a = dst_q + ADDR_W'(idx_q);
            ram_d_a    = res_q;
        end
    end

endmodule

// File: tb/tb_sdpram_rowop_seq.sv
// Directed bench for sdpram_rowop_seq with a 1-cycle-latency RAM model and an XOR row ALU.
module tb_sdpram_rowop_seq;

    localparam int DW = 256;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] src_a = '0, src_b = '0, dst = '0;
    logic [4:0]    nrows = '0;
    logic          busy, done, err;
    logic [AW-1:0] ram_addr_a, ram_addr_b;
    logic          ram_wen_a, ram_wen_b;
    logic [DW-1:0] ram_d_a, ram_d_b, ram_q_a, ram_q_b;
    logic          op_valid, res_ready;
    logic [DW-1:0] op_a, op_b;
    logic          op_ready = 1'b1;
    logic          res_valid;
    logic [DW-1:0] res_data;

    int n_checks = 0;
    int n_errors = 0;

    int r_done_cyc, r_ndone, r_nwr, r_nerr, r_err_cyc, r_busy_bad, r_stable_bad, r_act;

    always #5 clk = ~clk;

    sdpram_rowop_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .src_a      (src_a),
        .src_b      (src_b),
        .dst        (dst),
        .nrows      (nrows),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .ram_addr_a (ram_addr_a),
        .ram_wen_a  (ram_wen_a),
        .ram_d_a    (ram_d_a),
        .ram_q_a    (ram_q_a),
        .ram_addr_b (ram_addr_b),
        .ram_wen_b  (ram_wen_b),
        .ram_d_b    (ram_d_b),
        .ram_q_b    (ram_q_b),
        .op_valid   (op_valid),
        .op_a       (op_a),
        .op_b       (op_b),
        .op_ready   (op_ready),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready)
    );

    function automatic logic [DW-1:0] row_init(input int k);
        logic [31:0] w;
        w = 32'hDEAD_BEEF ^ (32'(k) * 32'h0101_0301);
        return {8{w}};
    endfunction

    // RAM model: registered reads on both ports, writes through port A only.
    logic [DW-1:0] mem [0:31];
    logic          do_init = 1'b0;
    always @(posedge clk) begin
        if (do_init) begin
            for (int k = 0; k < 32; k++) mem[k] <= row_init(k);
        end else if (ram_wen_a) begin
            mem[ram_addr_a] <= ram_d_a;
        end
        ram_q_a <= mem[ram_addr_a];
        ram_q_b <= mem[ram_addr_b];
    end

    // ALU model: result = op_a ^ op_b, offered the cycle after the operand handshake.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= 1'b0;
            res_data  <= '0;
        end else begin
            if (res_valid && res_ready) res_valid <= 1'b0;
            if (op_valid && op_ready) begin
                res_valid <= 1'b1;
                res_data  <= op_a ^ op_b;
            end
        end
    end

    task automatic init_mem;
        @(negedge clk);
        do_init = 1'b1;
        @(negedge clk);
        do_init = 1'b0;
    endtask

    // Issues one command and observes ncyc cycles; cycle 1 is the first after start is sampled.
    task automatic run_cmd(input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] d,
                           input logic [4:0] n, input int stall_cyc, input int stall_len,
                           input int exp_done, input bit repulse, input int ncyc);
        logic [DW-1:0] sav_a, sav_b;
        r_done_cyc = -1; r_err_cyc = -1; r_ndone = 0; r_nwr = 0; r_nerr = 0;
        r_busy_bad = 0; r_stable_bad = 0; r_act = 0;
        sav_a = '0; sav_b = '0;
        @(negedge clk);
        src_a = sa; src_b = sb; dst = d; nrows = n; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        src_a = 5'd31; src_b = 5'd31; dst = 5'd31; nrows = 5'd0;
        for (int c = 1; c <= ncyc; c++) begin
            if (done) begin
                r_ndone++;
                if (r_done_cyc < 0) r_done_cyc = c;
            end
            if (err) begin
                r_nerr++;
                if (r_err_cyc < 0) r_err_cyc = c;
            end
            if (ram_wen_a) r_nwr++;
            if (ram_wen_a || ram_wen_b || ram_addr_a != 0 || ram_addr_b != 0 || op_valid)
                r_act++;
            if (ram_wen_b || busy !== (c <= exp_done)) r_busy_bad++;
            if (stall_len > 0 && c == stall_cyc) begin
                sav_a = op_a;
                sav_b = op_b;
            end
            if (stall_len > 0 && c > stall_cyc && c <= stall_cyc + stall_len)
                if (op_a !== sav_a || op_b !== sav_b || !op_valid || ram_wen_a) r_stable_bad++;
            op_ready = !(stall_len > 0 && c >= stall_cyc && c < stall_cyc + stall_len);
            start = repulse && (c == 3 || c == 7);
            @(negedge clk);
        end
        op_ready = 1'b1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if ({busy, done, err, ram_wen_a, ram_wen_b, op_valid, res_ready} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {busy, done, err, ram_wen_a, ram_wen_b, op_valid, res_ready});
        end
        n_checks++;
        if ({ram_addr_a, ram_addr_b} !== 10'b0) begin
            n_errors++;
            $display("FAIL reset_addr: got %h want 0", {ram_addr_a, ram_addr_b});
        end
        n_checks++;
        if ((op_a | op_b | ram_d_a | ram_d_b) !== '0) begin
            n_errors++;
            $display("FAIL reset_data: nonzero data outputs");
        end
        @(negedge clk);
        rst_n = 1'b1;
        init_mem();
        run_cmd(5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clk);
            if (busy || ram_wen_a || ram_addr_a != 0 || ram_addr_b != 0) r_act++;
        end
        n_checks++;
        if (r_act !== 0) begin
            n_errors++;
            $display("FAIL idle_quiet: activity cycles %0d want 0", r_act);
        end
    endtask

    task automatic test_xor_rows;
        init_mem();
        run_cmd(5'd0, 5'd4, 5'd8, 5'd3, 0, 0, 16, 0, 20);
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (mem[8+k] !== (row_init(k) ^ row_init(4+k))) begin
                n_errors++;
                $display("FAIL xor_row%0d: got %h want %h", k, mem[8+k],
                         row_init(k) ^ row_init(4+k));
            end
        end
        n_checks++;
        if (r_nwr !== 3) begin
            n_errors++;
            $display("FAIL xor_writes: got %0d want 3", r_nwr);
        end
        n_checks++;
        if (r_done_cyc !== 16 || r_ndone !== 1) begin
            n_errors++;
            $display("FAIL xor_done: cycle %0d count %0d want 16/1", r_done_cyc, r_ndone);
        end
        n_checks++;
        if (r_busy_bad !== 0) begin
            n_errors++;
            $display("FAIL xor_busy: bad cycles %0d want 0", r_busy_bad);
        end
    endtask

    task automatic test_stall;
        init_mem();
        run_cmd(5'd0, 5'd4, 5'd8, 5'd3, 8, 4, 20, 0, 24);
        n_checks++;
        if (r_stable_bad !== 0) begin
            n_errors++;
            $display("FAIL stall_hold: bad cycles %0d want 0", r_stable_bad);
        end
        n_checks++;
        if (r_done_cyc !== 20 || r_ndone !== 1) begin
            n_errors++;
            $display("FAIL stall_done: cycle %0d count %0d want 20/1", r_done_cyc, r_ndone);
        end
        n_checks++;
        if (r_nwr !== 3 || mem[9] !== (row_init(1) ^ row_init(5))) begin
            n_errors++;
            $display("FAIL stall_write: writes %0d row9 %h", r_nwr, mem[9]);
        end
    endtask

    task automatic test_illegal;
        logic [4:0] bad_n [3] = '{5'd4, 5'd0, 5'd17};
        logic [4:0] bad_a [3] = '{5'd14, 5'd0, 5'd0};
        for (int t = 0; t < 3; t++) begin
            run_cmd(bad_a[t], 5'd0, 5'd0, bad_n[t], 0, 0, 0, 0, 6);
            n_checks++;
            if (r_err_cyc !== 1 || r_nerr !== 1) begin
                n_errors++;
                $display("FAIL err_pulse%0d: cycle %0d count %0d want 1/1", t, r_err_cyc,
                         r_nerr);
            end
            n_checks++;
            if (r_act !== 0 || r_busy_bad !== 0 || r_ndone !== 0) begin
                n_errors++;
                $display("FAIL err_quiet%0d: act %0d busy %0d done %0d want 0", t, r_act,
                         r_busy_bad, r_ndone);
            end
        end
    endtask

    task automatic test_reset_mid;
        init_mem();
        @(negedge clk);
        src_a = 5'd0; src_b = 5'd4; dst = 5'd12; nrows = 5'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (res_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL mid_state: res_ready %b want 1 in cycle 9", res_ready);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, err, ram_wen_a, op_valid, res_ready, ram_addr_a, ram_addr_b} !== '0
            || (op_a | op_b | ram_d_a) !== '0) begin
            n_errors++;
            $display("FAIL mid_outputs: busy %b wen %b addr %h want all 0", busy, ram_wen_a,
                     ram_addr_a);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++;
        if (mem[12] !== (row_init(0) ^ row_init(4))) begin
            n_errors++;
            $display("FAIL mid_row0: got %h want %h", mem[12], row_init(0) ^ row_init(4));
        end
        n_checks++;
        if (mem[13] !== row_init(13)) begin
            n_errors++;
            $display("FAIL mid_row1: got %h want %h", mem[13], row_init(13));
        end
        run_cmd(5'd0, 5'd4, 5'd12, 5'd3, 0, 0, 16, 0, 20);
        n_checks++;
        if (r_done_cyc !== 16 || mem[13] !== (row_init(1) ^ row_init(5))) begin
            n_errors++;
            $display("FAIL mid_rerun: done %0d row13 %h", r_done_cyc, mem[13]);
        end
    endtask

    task automatic test_back_to_back;
        init_mem();
        run_cmd(5'd2, 5'd5, 5'd2, 5'd2, 0, 0, 11, 1, 15);
        n_checks++;
        if (mem[2] !== (row_init(2) ^ row_init(5))) begin
            n_errors++;
            $display("FAIL inplace_row2: got %h want %h", mem[2], row_init(2) ^ row_init(5));
        end
        n_checks++;
        if (mem[3] !== (row_init(3) ^ row_init(6))) begin
            n_errors++;
            $display("FAIL inplace_row3: got %h want %h", mem[3], row_init(3) ^ row_init(6));
        end
        n_checks++;
        if (r_ndone !== 1 || r_done_cyc !== 11 || r_nerr !== 0 || r_nwr !== 2) begin
            n_errors++;
            $display("FAIL inplace_ctrl: done %0d@%0d err %0d writes %0d want 1@11/0/2",
                     r_ndone, r_done_cyc, r_nerr, r_nwr);
        end
    endtask

    initial begin
        test_reset();
        test_xor_rows();
        test_stall();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
